// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line scanner: attribute field layout,
// sprite height decode, scanner FSM states and the hit record.
package sprite_pkg;

  localparam int unsigned ATTR_W       = 32;
  localparam int unsigned IDX_W        = 7;
  localparam int unsigned RD_ADDR_W    = 8;
  localparam int unsigned ROW_W        = 6;
  localparam int unsigned HEIGHT_W     = 7;

  // word 2n
  localparam int unsigned W0_ADDR_LSB  = 0;
  localparam int unsigned W0_ADDR_W    = 12;
  localparam int unsigned W0_MODE_BIT  = 15;
  localparam int unsigned W0_X_LSB     = 16;
  localparam int unsigned W0_X_W       = 10;

  // word 2n+1
  localparam int unsigned W1_Y_LSB     = 0;
  localparam int unsigned W1_Z_LSB     = 18;
  localparam int unsigned W1_Z_W       = 2;
  localparam int unsigned W1_PAL_LSB   = 24;
  localparam int unsigned W1_PAL_W     = 4;
  localparam int unsigned W1_WCODE_LSB = 28;
  localparam int unsigned W1_HCODE_LSB = 30;
  localparam int unsigned W1_CODE_W    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_EVAL,
    ST_HOLD,
    ST_DONE,
    ST_DRAIN
  } scan_state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [ATTR_W-1:0] attr0;
    logic [ATTR_W-1:0] attr1;
    logic [ROW_W-1:0]  row;
  } hit_rec_t;

  // Sprite height in lines: 8, 16, 32 or 64.
  function automatic logic [HEIGHT_W-1:0] sprite_height(input logic [W1_CODE_W-1:0] hcode);
    return HEIGHT_W'(8) << hcode;
  endfunction

endpackage

// File: rtl/sprite_hit_eval.sv
// Vertical intersection test of one sprite against the current line.
// Purely combinational so it can be exercised on its own.
module sprite_hit_eval
  import sprite_pkg::*;
#(
  parameter int unsigned LINE_W = 10
) (
  input  logic [LINE_W-1:0] line_i,
  input  logic [31:0]       word1_i,
  output logic              hit_o,
  output logic [ROW_W-1:0]  row_o
);

  logic [LINE_W-1:0] diff;
  logic [LINE_W-1:0] height;
  logic              unused_fields;

  assign unused_fields = ^{word1_i[W1_Z_LSB-1:LINE_W],
                           word1_i[W1_HCODE_LSB-1:W1_Z_LSB+W1_Z_W]};

  // Modular distance below the sprite top; a wrapped sprite still matches.
  always_comb begin
    diff   = line_i - word1_i[W1_Y_LSB +: LINE_W];
    height = LINE_W'(sprite_height(word1_i[W1_HCODE_LSB +: W1_CODE_W]));
    hit_o  = (word1_i[W1_Z_LSB +: W1_Z_W] != '0) && (diff < height);
    row_o  = diff[ROW_W-1:0];
  end

endmodule

// File: rtl/sprite_line_scanner.sv
// Per-line sprite scanner: walks the attribute RAM in index order and
// streams every sprite intersecting the latched line to the renderer.
module sprite_line_scanner
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 128,
  parameter int unsigned MAX_HITS    = 16,
  parameter int unsigned LINE_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_start_i,
  input  logic [LINE_W-1:0] line_idx_i,
  input  logic              enable_i,
  output logic [7:0]        rd_addr_o,
  input  logic [31:0]       rd_data_i,
  output logic              hit_valid_o,
  input  logic              hit_ready_i,
  output logic [6:0]        hit_idx_o,
  output logic [31:0]       hit_attr0_o,
  output logic [31:0]       hit_attr1_o,
  output logic [5:0]        hit_row_o,
  output logic              scan_busy_o,
  output logic              scan_done_o,
  output logic              overflow_o
);

  localparam int unsigned      CNT_W     = $clog2(MAX_HITS + 1);
  localparam logic [CNT_W-1:0] HIT_LIMIT = CNT_W'(MAX_HITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SPRITES - 1);

  scan_state_e       state_q, state_d;
  logic [IDX_W-1:0]  n_q, n_d, n_inc;
  logic [LINE_W-1:0] line_q, line_d;
  logic [31:0]       word0_q, word0_d;
  logic [31:0]       word1_q, word1_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic              ovf_q, ovf_d;
  hit_rec_t          out_q, out_d;
  logic              out_valid_q, out_valid_d;

  logic              start_acc;
  logic              out_free;
  logic [31:0]       eval_word1;
  logic              eval_hit;
  logic [ROW_W-1:0]  eval_row;

  assign start_acc  = line_start_i & enable_i;
  assign out_free   = ~out_valid_q | hit_ready_i;
  assign n_inc      = n_q + IDX_W'(1);
  // In HOLD the RAM output already shows the next sprite's word0, so the
  // pending word1 comes from the capture register instead.
  assign eval_word1 = (state_q == ST_HOLD) ? word1_q : rd_data_i;

  sprite_hit_eval #(
    .LINE_W (LINE_W)
  ) u_hit_eval (
    .line_i  (line_q),
    .word1_i (eval_word1),
    .hit_o   (eval_hit),
    .row_o   (eval_row)
  );

  // Next-state, RAM address, hit loading and scan bookkeeping.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    line_d      = line_q;
    word0_d     = word0_q;
    word1_d     = word1_q;
    hit_cnt_d   = hit_cnt_q;
    ovf_d       = ovf_q;
    out_d       = out_q;
    out_valid_d = out_valid_q & ~hit_ready_i;
    rd_addr_o   = '0;
    scan_done_o = 1'b0;

    unique case (state_q)
      ST_IDLE: ;
      ST_RD0: begin
        rd_addr_o = {n_q, 1'b0};
        state_d   = ST_RD1;
      end
      ST_RD1: begin
        rd_addr_o = {n_q, 1'b1};
        word0_d   = rd_data_i;
        state_d   = ST_EVAL;
      end
      ST_EVAL: begin
        // Prefetch the next sprite's word0 so the walk is 2 cycles/sprite.
        rd_addr_o = {n_inc, 1'b0};
        word1_d   = rd_data_i;
        if (eval_hit && (hit_cnt_q == HIT_LIMIT)) begin
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else if (eval_hit && !out_free) begin
          state_d = ST_HOLD;
        end else begin
          if (eval_hit) begin
            out_d       = '{idx: n_q, attr0: word0_q, attr1: eval_word1, row: eval_row};
            out_valid_d = 1'b1;
            hit_cnt_d   = hit_cnt_q + CNT_W'(1);
          end
          n_d     = n_inc;
          state_d = (n_q == LAST_IDX) ? ST_DONE : ST_RD1;
        end
      end
      ST_HOLD: begin
        // Address held at the next word0; its data is ready for RD1.
        rd_addr_o = {n_inc, 1'b0};
        if (out_free) begin
          out_d       = '{idx: n_q, attr0: word0_q, attr1: eval_word1, row: eval_row};
          out_valid_d = 1'b1;
          hit_cnt_d   = hit_cnt_q + CNT_W'(1);
          n_d         = n_inc;
          state_d     = (n_q == LAST_IDX) ? ST_DONE : ST_RD1;
        end
      end
      ST_DONE: begin
        scan_done_o = 1'b1;
        state_d     = out_valid_d ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (!out_valid_d) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_acc) begin
      state_d     = ST_RD0;
      n_d         = '0;
      line_d      = line_idx_i;
      ovf_d       = 1'b0;
      hit_cnt_d   = '0;
      out_valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      line_q      <= '0;
      word0_q     <= '0;
      word1_q     <= '0;
      hit_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      line_q      <= line_d;
      word0_q     <= word0_d;
      word1_q     <= word1_d;
      hit_cnt_q   <= hit_cnt_d;
      ovf_q       <= ovf_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign hit_valid_o = out_valid_q;
  assign hit_idx_o   = out_q.idx;
  assign hit_attr0_o = out_q.attr0;
  assign hit_attr1_o = out_q.attr1;
  assign hit_row_o   = out_q.row;
  assign scan_busy_o = (state_q != ST_IDLE);
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Self-checking bench for sprite_line_scanner with a behavioural RAM and
// a reference model computing expected hits per line from attribute rules.
module tb_sprite_line_scanner;

  typedef struct packed {
    logic [6:0]  idx;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [5:0]  row;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  line_idx = '0;
  logic        enable = 1'b1;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic        hit_valid;
  logic        hit_ready = 1'b1;
  logic [6:0]  hit_idx;
  logic [31:0] hit_attr0, hit_attr1;
  logic [5:0]  hit_row;
  logic        scan_busy, scan_done, overflow;

  logic [31:0] mem [256];
  int          rdy_mode = 0;   // 0 always, 1 one-of-three, 2 random, 3 never
  int          rdy_phase = 0;

  int   errors = 0;
  int   checks = 0;
  rec_t got_q[$];
  rec_t exp_q[$];
  bit   exp_ovf;
  int   done_cnt = 0;
  int   stab_viol = 0;
  bit   prev_stall = 0;
  rec_t prev_rec;
  rec_t cur_rec;
  int   gb, db, sb;

  assign cur_rec = {hit_idx, hit_attr0, hit_attr1, hit_row};

  sprite_line_scanner #(
    .NUM_SPRITES (128),
    .MAX_HITS    (16),
    .LINE_W      (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_start_i (line_start),
    .line_idx_i   (line_idx),
    .enable_i     (enable),
    .rd_addr_o    (rd_addr),
    .rd_data_i    (rd_data),
    .hit_valid_o  (hit_valid),
    .hit_ready_i  (hit_ready),
    .hit_idx_o    (hit_idx),
    .hit_attr0_o  (hit_attr0),
    .hit_attr1_o  (hit_attr1),
    .hit_row_o    (hit_row),
    .scan_busy_o  (scan_busy),
    .scan_done_o  (scan_done),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  // Synchronous-read attribute RAM.
  always @(posedge clk) rd_data <= mem[rd_addr];

  // Ready pattern, changed just after the active edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: hit_ready = 1'b1;
      1: begin hit_ready = (rdy_phase == 0); rdy_phase = (rdy_phase + 1) % 3; end
      2: hit_ready = 1'($urandom_range(0, 1));
      default: hit_ready = 1'b0;
    endcase
  end

  // Transfer collector and stall-stability watcher.
  always @(negedge clk) begin
    if (hit_valid && hit_ready) got_q.push_back(cur_rec);
    if (prev_stall && hit_valid && (cur_rec !== prev_rec)) stab_viol++;
    prev_stall = hit_valid && !hit_ready;
    prev_rec   = cur_rec;
    if (scan_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_w1(input logic [1:0] hc, input logic [1:0] z,
                                        input logic [9:0] y, input logic [31:0] noise);
    logic [31:0] w;
    w = noise;
    w[31:30] = hc;
    w[19:18] = z;
    w[9:0]   = y;
    return w;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic put_sprite(input int n, input logic [1:0] hc, input logic [1:0] z, input logic [9:0] y);
    mem[2*n]   = $urandom;
    mem[2*n+1] = mk_w1(hc, z, y, $urandom);
  endtask

  // Reference: walk sprites in order, keep first 16 hits, note any extra.
  task automatic build_expected(input logic [9:0] line);
    int unsigned d, h;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int n = 0; n < 128; n++) begin
      d = (int'(line) + 1024 - int'(mem[2*n+1][9:0])) % 1024;
      h = 8 << mem[2*n+1][31:30];
      if (mem[2*n+1][19:18] != 2'd0 && d < h) begin
        if (exp_q.size() == 16) begin
          exp_ovf = 1'b1;
          break;
        end
        exp_q.push_back({7'(n), mem[2*n], mem[2*n+1], 6'(d)});
      end
    end
  endtask

  task automatic snapshot();
    gb = got_q.size();
    db = done_cnt;
    sb = stab_viol;
  endtask

  task automatic start_line(input logic [9:0] l);
    line_idx   = l;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic finish_scan(input string tag, input int max_lat);
    int cyc;
    cyc = 1;
    while (!scan_done && cyc < 3000) begin @(negedge clk); cyc++; end
    check({tag, " done_latency_ok"}, 96'(cyc <= max_lat), 96'(1));
    while (scan_busy && cyc < 6000) begin @(negedge clk); cyc++; end
    check({tag, " busy_end"}, 96'(scan_busy), 96'(0));
    repeat (3) @(negedge clk);
    check({tag, " transfers"}, 96'(got_q.size() - gb), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (gb + i < got_q.size())
        check($sformatf("%s hit%0d", tag, i), 96'(got_q[gb+i]), 96'(exp_q[i]));
    check({tag, " overflow"}, 96'(overflow), 96'(exp_ovf));
    check({tag, " done_pulses"}, 96'(done_cnt - db), 96'(1));
    check({tag, " stall_stable"}, 96'(stab_viol - sb), 96'(0));
  endtask

  task automatic run_scan(input logic [9:0] l, input string tag, input int max_lat);
    build_expected(l);
    snapshot();
    start_line(l);
    finish_scan(tag, max_lat);
  endtask

  function automatic logic [95:0] all_outs();
    return 96'({rd_addr, hit_valid, hit_idx, hit_attr0, hit_attr1, hit_row,
                scan_busy, scan_done, overflow});
  endfunction

  initial begin
    clear_mem();

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted mid-scan
    for (int n = 0; n < 128; n++) put_sprite(n, 2'($urandom), 2'($urandom), 10'(40 - $urandom_range(0, 60)));
    rdy_mode = 2;
    start_line(10'd40);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midscan_reset_outputs", all_outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    @(negedge clk);

    // Disabled start is ignored
    enable = 1'b0;
    start_line(10'd5);
    check("disabled_start_busy", 96'(scan_busy), 96'(0));
    enable = 1'b1;
    @(negedge clk);

    // Single hit, z=0 sprite ignored, latency bound
    clear_mem();
    put_sprite(5, 2'd1, 2'd3, 10'd100);
    put_sprite(9, 2'd0, 2'd0, 10'd110);
    run_scan(10'd110, "basic", 260);
    check("basic_count_const", 96'(exp_q.size()), 96'(1));

    // Vertical wrap
    clear_mem();
    put_sprite(0, 2'd1, 2'd1, 10'd1020);
    run_scan(10'd3, "wrap_hit", 260);
    if (got_q.size() > gb) check("wrap_row", 96'(got_q[gb].row), 96'(7));
    mem[1] = mk_w1(2'd0, 2'd1, 10'd1020, mem[1]);
    run_scan(10'd4, "wrap_miss", 260);

    // Backpressure, one-of-three ready
    clear_mem();
    put_sprite(2, 2'd2, 2'd1, 10'd290);
    put_sprite(7, 2'd0, 2'd2, 10'd295);
    put_sprite(8, 2'd3, 2'd3, 10'd250);
    put_sprite(40, 2'd1, 2'd1, 10'd300);
    put_sprite(41, 2'd0, 2'd1, 10'd301);
    rdy_mode = 1;
    run_scan(10'd300, "backpressure", 2999);
    rdy_mode = 0;

    // Hit limit overflow, then cleared on next start
    clear_mem();
    for (int n = 0; n < 20; n++) put_sprite(n, 2'd0, 2'd2, 10'd50);
    run_scan(10'd50, "overflow", 260);
    build_expected(10'd600);
    snapshot();
    start_line(10'd600);
    check("overflow_cleared", 96'(overflow), 96'(0));
    finish_scan("after_overflow", 260);

    // Abort mid-scan with a pending hit
    clear_mem();
    for (int n = 0; n < 4; n++) put_sprite(n, 2'd0, 2'd1, 10'd200);
    put_sprite(10, 2'd0, 2'd3, 10'd500);
    put_sprite(11, 2'd1, 2'd2, 10'd495);
    rdy_mode = 3;
    snapshot();
    start_line(10'd203);
    repeat (48) @(negedge clk);
    check("abort_pending_valid", 96'(hit_valid), 96'(1));
    check("abort_pending_idx", 96'(hit_idx), 96'(0));
    build_expected(10'd502);
    rdy_mode = 0;
    start_line(10'd502);
    check("abort_valid_dropped", 96'(hit_valid), 96'(0));
    check("abort_rd_addr", 96'(rd_addr), 96'(0));
    finish_scan("abort", 2999);

    // Randomized lines
    for (int t = 0; t < 4; t++) begin
      logic [9:0] l;
      l = 10'($urandom);
      for (int n = 0; n < 128; n++)
        put_sprite(n, 2'($urandom), 2'($urandom), 10'(int'(l) + 1024 - $urandom_range(0, 200)));
      rdy_mode = (t == 0) ? 0 : 2;
      run_scan(l, $sformatf("random%0d", t), (t == 0) ? 260 : 2999);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
